dmem_arbiter: RTL

//  Shares the single data-memory port (RAM + LED/UART MMIO, 1-cycle registered read) between two requesters.

---
 rtl/riscv_pkg.sv | 35 +++
 rtl/dmem_rsp_router.sv | 47 ++++
 rtl/dmem_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared widths, size codes and data-memory arbiter types
// Purpose: common definitions imported by the data-memory arbiter and its response router.
// Contents: XLEN/ALEN, F3_* load/store size codes, arb_state_t, rsp_owner_t, mem_req_t.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ALEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ARB_NORMAL,
    ARB_BOOST,
    ARB_LOCKED
  } arb_state_t;

  typedef enum logic [1:0] {
    RSP_NONE,
    RSP_P0,
    RSP_P1
  } rsp_owner_t;

  typedef struct packed {
    logic            we;
    logic [3:0]      be;
    logic [2:0]      funct3;
    logic [ALEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/dmem_rsp_router.sv
// rtl/dmem_rsp_router.sv - one-entry load owner tag and read-data demux
// Purpose: remembers which port issued the load in the previous cycle and
//   steers the memory's registered read data to that port only.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   load_issue_i       a load was issued this cycle
//   load_port_i        issuing port (0 or 1)
//   mem_rdata_i        registered read data from memory
//   rspN_valid_o/rdata_o  per-port response, rdata forced to 0 when not valid
module dmem_rsp_router
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_issue_i,
  input  logic            load_port_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            rsp0_valid_o,
  output logic [XLEN-1:0] rsp0_rdata_o,
  output logic            rsp1_valid_o,
  output logic [XLEN-1:0] rsp1_rdata_o
);

  rsp_owner_t owner_q, owner_d;

  // The tag lives for exactly one cycle: a new load overwrites it, no load clears it.
  always_comb begin
    owner_d = RSP_NONE;
    if (load_issue_i) begin
      owner_d = load_port_i ? RSP_P1 : RSP_P0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= RSP_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign rsp0_valid_o = (owner_q == RSP_P0);
  assign rsp1_valid_o = (owner_q == RSP_P1);
  assign rsp0_rdata_o = rsp0_valid_o ? mem_rdata_i : '0;
  assign rsp1_rdata_o = rsp1_valid_o ? mem_rdata_i : '0;

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter with starvation boost and burst lock
// Purpose: shares the single data-memory port between the CPU MEM stage (port 0,
//   fixed priority) and the debug/boot DMA (port 1). At most one access per cycle;
//   load data is routed back to its owner one cycle after issue.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   reqN_valid/ready               request handshake, issue = valid && ready
//   reqN_we/be/funct3/addr/wdata   request fields
//   req1_lock                      port 1 asks to hold the memory for a burst
//   rspN_valid/rdata               load response, one cycle after issue
//   mem_we/be/funct3/addr/wdata    to memory, all zero when nobody wins
//   mem_rdata                      registered read data from memory
module dmem_arbiter
  import riscv_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int LOCK_MAX     = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic            req0_we,
  input  logic [3:0]      req0_be,
  input  logic [2:0]      req0_funct3,
  input  logic [ALEN-1:0] req0_addr,
  input  logic [XLEN-1:0] req0_wdata,
  output logic            rsp0_valid,
  output logic [XLEN-1:0] rsp0_rdata,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic            req1_we,
  input  logic [3:0]      req1_be,
  input  logic [2:0]      req1_funct3,
  input  logic [ALEN-1:0] req1_addr,
  input  logic [XLEN-1:0] req1_wdata,
  output logic            rsp1_valid,
  output logic [XLEN-1:0] rsp1_rdata,
  input  logic            req1_lock,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  output logic [2:0]      mem_funct3,
  output logic [ALEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);

  arb_state_t      state_q, state_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [LW-1:0]   lock_q, lock_d;
  logic            grant0, grant1, yield;
  mem_req_t        req0, req1, mem_req;

  assign req0 = {req0_we, req0_be, req0_funct3, req0_addr, req0_wdata};
  assign req1 = {req1_we, req1_be, req1_funct3, req1_addr, req1_wdata};

  // A full lock with port 0 waiting spends one cycle granting nobody so the
  // state can drop back to normal, where port 0 then wins on priority.
  assign yield = (state_q == ARB_LOCKED) && (lock_q == LW'(LOCK_MAX)) && req0_valid;

  // Grants are gated by rst_n so the handshake and memory controls read as
  // idle for the whole time reset is asserted, not just after the first edge.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n) begin
      case (state_q)
        ARB_NORMAL: begin
          grant0 = req0_valid;
          grant1 = !req0_valid && req1_valid;
        end
        ARB_BOOST: begin
          grant1 = req1_valid;
          grant0 = !req1_valid && req0_valid;
        end
        ARB_LOCKED: begin
          grant1 = req1_valid && !yield;
        end
        default: begin
          grant0 = 1'b0;
          grant1 = 1'b0;
        end
      endcase
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign mem_req    = grant0 ? req0 : (grant1 ? req1 : '0);
  assign mem_we     = mem_req.we;
  assign mem_be     = mem_req.be;
  assign mem_funct3 = mem_req.funct3;
  assign mem_addr   = mem_req.addr;
  assign mem_wdata  = mem_req.wdata;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    lock_d   = lock_q;

    if (grant1) begin
      starve_d = '0;
    end else if (req1_valid && (starve_q != SW'(STARVE_LIMIT))) begin
      starve_d = starve_q + SW'(1);
    end

    case (state_q)
      ARB_NORMAL: begin
        if (grant1 && req1_lock) begin
          state_d = ARB_LOCKED;
          lock_d  = LW'(1);
        end else if (starve_d == SW'(STARVE_LIMIT)) begin
          // Using the next count lets port 1 win on the very cycle the limit is hit.
          state_d = ARB_BOOST;
        end
      end
      ARB_BOOST: begin
        if (grant1 || !req1_valid) begin
          state_d  = ARB_NORMAL;
          starve_d = '0;
        end
      end
      ARB_LOCKED: begin
        if (grant1 && (lock_q != LW'(LOCK_MAX))) begin
          lock_d = lock_q + LW'(1);
        end
        if (!req1_lock || yield) begin
          state_d = ARB_NORMAL;
          lock_d  = '0;
        end
      end
      default: begin
        state_d = ARB_NORMAL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_NORMAL;
      starve_q <= '0;
      lock_q   <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      lock_q   <= lock_d;
    end
  end

  dmem_rsp_router u_rsp_router (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_issue_i ((grant0 || grant1) && !mem_req.we),
    .load_port_i  (grant1),
    .mem_rdata_i  (mem_rdata),
    .rsp0_valid_o (rsp0_valid),
    .rsp0_rdata_o (rsp0_rdata),
    .rsp1_valid_o (rsp1_valid),
    .rsp1_rdata_o (rsp1_rdata)
  );

endmodule
